// File: rtl/jk_seq_if.sv
// Bus between the JK sequence driver and its host/JK bank: memory writes,
// playback control, bank readback and J/K excitation outputs.
interface jk_seq_if #(
  parameter int WIDTH = 4,
  parameter int AW    = 3
);
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW:0]      seq_len;
  logic             start;
  logic [WIDTH-1:0] q_in;
  logic [WIDTH-1:0] j_out;
  logic [WIDTH-1:0] k_out;
  logic             busy;
  logic             done;
  logic             error;
  logic [AW-1:0]    err_step;
  logic [WIDTH-1:0] err_q;

  modport master (
    output wr_en, wr_addr, wr_data, seq_len, start, q_in,
    input  j_out, k_out, busy, done, error, err_step, err_q
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, seq_len, start, q_in,
    output j_out, k_out, busy, done, error, err_step, err_q
  );
endinterface

// File: rtl/jk_seq_driver.sv
// Steps an external JK flop bank through a stored sequence of target words,
// deriving J/K from the excitation table and verifying each step by readback.
//
// state   | meaning
// IDLE    | waiting for start after reset
// APPLY   | j_out/k_out driven for one cycle; bank samples them at the closing edge
// CHECK   | j/k back to hold; q_in compared with the current target
// DONE    | whole sequence matched; done held until next start
// ERROR   | readback mismatch; error/err_step/err_q held until next start
module jk_seq_driver #(
  parameter int WIDTH      = 4,
  parameter int DEPTH      = 8,
  parameter int AW         = 3,
  parameter int USE_TOGGLE = 0
) (
  input  logic     clock,
  input  logic     reset_n,
  jk_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [AW:0]      len_q, len_d;
  logic [AW-1:0]    step_q, step_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [AW-1:0]    err_step_q, err_step_d;
  logic [WIDTH-1:0] err_q_q, err_q_d;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             busy;
  logic [AW:0]      len_sat;
  logic [AW-1:0]    step_inc;
  logic             last_step;
  logic [WIDTH-1:0] exc_tgt;
  logic [WIDTH-1:0] exc_j;
  logic [WIDTH-1:0] exc_k;

  assign busy     = (state_q == S_APPLY) || (state_q == S_CHECK);
  assign len_sat  = (bus.seq_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.seq_len;
  assign step_inc = step_q + AW'(1);
  assign last_step = ({1'b0, step_q} == (len_q - (AW+1)'(1)));

  // The next excitation is always computed against the live bank value: from
  // IDLE/DONE/ERROR it targets entry 0, from CHECK it targets the next entry.
  assign exc_tgt = (state_q == S_CHECK) ? mem[step_inc] : mem[0];

  generate
    if (USE_TOGGLE != 0) begin : g_toggle
      assign exc_j = bus.q_in ^ exc_tgt;
      assign exc_k = bus.q_in ^ exc_tgt;
    end else begin : g_setreset
      assign exc_j = ~bus.q_in & exc_tgt;
      assign exc_k = bus.q_in & ~exc_tgt;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (bus.wr_en && !busy) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      step_q     <= '0;
      j_q        <= '0;
      k_q        <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_step_q <= '0;
      err_q_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      step_q     <= step_d;
      j_q        <= j_d;
      k_q        <= k_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_step_q <= err_step_d;
      err_q_q    <= err_q_d;
    end
  end

  // j/k default to hold so they can only be nonzero for the cycle in APPLY.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    step_d     = step_q;
    j_d        = '0;
    k_d        = '0;
    done_d     = done_q;
    error_d    = error_q;
    err_step_d = err_step_q;
    err_q_d    = err_q_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.start) begin
          len_d      = len_sat;
          step_d     = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_step_d = '0;
          err_q_d    = '0;
          if (len_sat == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_APPLY;
            j_d     = exc_j;
            k_d     = exc_k;
          end
        end
      end
      S_APPLY: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (bus.q_in != mem[step_q]) begin
          state_d    = S_ERROR;
          error_d    = 1'b1;
          err_step_d = step_q;
          err_q_d    = bus.q_in;
        end else if (last_step) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_APPLY;
          step_d  = step_inc;
          j_d     = exc_j;
          k_d     = exc_k;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.j_out    = j_q;
  assign bus.k_out    = k_q;
  assign bus.busy     = busy;
  assign bus.done     = done_q;
  assign bus.error    = error_q;
  assign bus.err_step = err_step_q;
  assign bus.err_q    = err_q_q;

endmodule

// File: tb/tb_jk_seq_driver.sv
// Scoreboard bench: two driver instances (set/reset and toggle encodings),
// each with a behavioural JK bank, checked against a sequence-level model.
module tb_jk_seq_driver;

  localparam int W  = 4;
  localparam int D  = 8;
  localparam int AW = 3;

  typedef struct packed {
    logic        is_end;
    logic [3:0]  j;
    logic [3:0]  k;
    logic        done;
    logic        err;
    logic [2:0]  step;
    logic [3:0]  q;
    logic [31:0] cyc;
  } exp_t;

  logic          clock;
  logic          reset_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [AW:0]   seq_len;
  logic          start;
  logic          bank_clr;
  logic [W-1:0]  stuck;

  logic [W-1:0]  mem_m [D];
  exp_t          q0[$];
  exp_t          q1[$];
  int            n_checks = 0;
  int            n_pass   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void push_exp(input int g, input exp_t e);
    if (g == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic bit pop_exp(input int g, output exp_t e);
    e = '0;
    if (g == 0) begin
      if (q0.size() == 0) return 1'b0;
      e = q0.pop_front();
    end else begin
      if (q1.size() == 0) return 1'b0;
      e = q1.pop_front();
    end
    return 1'b1;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : lane
      localparam int G = gi;
      jk_seq_if #(.WIDTH(W), .AW(AW)) bus ();
      logic [W-1:0] bank;
      int           cnt;
      logic         pb, pa, pd, pe, ap;
      exp_t         e;

      assign bus.wr_en   = wr_en;
      assign bus.wr_addr = wr_addr;
      assign bus.wr_data = wr_data;
      assign bus.seq_len = seq_len;
      assign bus.start   = start;
      assign bus.q_in    = bank & ~stuck;

      jk_seq_driver #(.WIDTH(W), .DEPTH(D), .AW(AW), .USE_TOGGLE(G)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
      );

      // External JK bank: not affected by the driver's reset.
      always @(posedge clock) begin
        if (bank_clr) bank <= '0;
        else          bank <= (bus.j_out & ~bank) | (~bus.k_out & bank);
        if (start && !bus.busy) cnt <= 0;
        else                    cnt <= cnt + 1;
      end

      always @(negedge clock) begin
        if (!reset_n) begin
          pb = 1'b0; pa = 1'b0; pd = 1'b0; pe = 1'b0;
        end else begin
          ap = bus.busy && (!pb || !pa);
          if (ap) begin
            if (pop_exp(G, e) && !e.is_end) begin
              check($sformatf("lane%0d apply j", G), 32'(bus.j_out), 32'(e.j));
              check($sformatf("lane%0d apply k", G), 32'(bus.k_out), 32'(e.k));
            end else begin
              check($sformatf("lane%0d unexpected apply", G), 32'd1, 32'd0);
            end
          end else begin
            check($sformatf("lane%0d hold jk", G), 32'({bus.j_out, bus.k_out}), 32'd0);
          end
          if ((bus.done && !pd) || (bus.error && !pe)) begin
            if (pop_exp(G, e) && e.is_end) begin
              check($sformatf("lane%0d done", G), 32'(bus.done), 32'(e.done));
              check($sformatf("lane%0d error", G), 32'(bus.error), 32'(e.err));
              check($sformatf("lane%0d err_step", G), 32'(bus.err_step), 32'(e.step));
              check($sformatf("lane%0d err_q", G), 32'(bus.err_q), 32'(e.q));
              check($sformatf("lane%0d busy at end", G), 32'(bus.busy), 32'd0);
              check($sformatf("lane%0d end latency", G), 32'(cnt), e.cyc);
            end else begin
              check($sformatf("lane%0d unexpected end", G), 32'd1, 32'd0);
            end
          end
          pb = bus.busy; pa = ap; pd = bus.done; pe = bus.error;
        end
      end
    end
  endgenerate

  // Sequence-level model: walk the targets, apply JK semantics to the true bank,
  // and stop at the first readback that differs from its target.
  task automatic predict(input int g, input int len_req);
    int len;
    logic [3:0] b, rd, t, j, k;
    exp_t e;
    len = (len_req > D) ? D : len_req;
    b   = (g == 0) ? lane[0].bank : lane[1].bank;
    rd  = b & ~stuck;
    for (int s = 0; s < len; s++) begin
      t = mem_m[s];
      if (g == 0) begin j = ~rd & t; k = rd & ~t; end
      else        begin j = rd ^ t;  k = rd ^ t;  end
      e = '0; e.j = j; e.k = k;
      push_exp(g, e);
      b  = (j & ~b) | (~k & b);
      rd = b & ~stuck;
      if (rd != t) begin
        e = '0; e.is_end = 1'b1; e.err = 1'b1; e.step = s[2:0]; e.q = rd; e.cyc = 32'(2*s + 2);
        push_exp(g, e);
        return;
      end
    end
    e = '0; e.is_end = 1'b1; e.done = 1'b1; e.cyc = 32'(2*len);
    push_exp(g, e);
  endtask

  task automatic write_word(input int a, input logic [3:0] d, input bit taken);
    wr_en = 1'b1; wr_addr = a[AW-1:0]; wr_data = d;
    @(posedge clock); #1;
    wr_en = 1'b0;
    if (taken) mem_m[a] = d;
  endtask

  task automatic pulse_start(input int len);
    seq_len = len[AW:0]; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 100 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clock);
    check("drain within budget", 32'(q0.size() + q1.size()), 32'd0);
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic run(input int len);
    predict(0, len);
    predict(1, len);
    pulse_start(len);
    drain();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " lane0 outputs"}, 32'({lane[0].bus.j_out, lane[0].bus.k_out, lane[0].bus.busy,
          lane[0].bus.done, lane[0].bus.error, lane[0].bus.err_step, lane[0].bus.err_q}), 32'd0);
    check({tag, " lane1 outputs"}, 32'({lane[1].bus.j_out, lane[1].bus.k_out, lane[1].bus.busy,
          lane[1].bus.done, lane[1].bus.error, lane[1].bus.err_step, lane[1].bus.err_q}), 32'd0);
  endtask

  initial begin
    logic [3:0] init_words [D];
    init_words[0] = 4'b0001; init_words[1] = 4'b0011; init_words[2] = 4'b0110; init_words[3] = 4'b1111;
    init_words[4] = 4'b1000; init_words[5] = 4'b0101; init_words[6] = 4'b1010; init_words[7] = 4'b0000;

    reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    seq_len = '0; start = 1'b0; bank_clr = 1'b1; stuck = '0;
    repeat (3) @(posedge clock);
    #1;
    check_outputs_zero("reset");
    reset_n = 1'b1; bank_clr = 1'b0;

    for (int a = 0; a < D; a++) write_word(a, init_words[a], 1'b1);

    // Set/reset and toggle encodings from bank=0000 over 0001,0011,0110,1111.
    run(4);
    check("lane0 final bank", 32'(lane[0].bank), 32'hF);
    check("lane1 final bank", 32'(lane[1].bank), 32'hF);

    // Bit 2 of the readback stuck low: mismatch at step 2 with q=0010.
    stuck = 4'b0100;
    run(4);
    stuck = '0;

    // Zero-length and over-length sequences.
    run(0);
    run(12);

    // Start and write while busy are both ignored.
    predict(0, 4);
    predict(1, 4);
    pulse_start(4);
    @(posedge clock); #1;
    seq_len = 4'd1; start = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = 4'b1111;
    @(posedge clock); #1;
    start = 1'b0; wr_en = 1'b0;
    drain();
    run(2);

    // Reset during APPLY of step 1: outputs clear at once and the bank holds.
    predict(0, 4);
    predict(1, 4);
    pulse_start(4);
    @(posedge clock);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check_outputs_zero("async reset");
    q0.delete();
    q1.delete();
    @(posedge clock); #1;
    check("lane0 bank held", 32'(lane[0].bank), 32'h1);
    check("lane1 bank held", 32'(lane[1].bank), 32'h1);
    reset_n = 1'b1;
    @(posedge clock); #1;
    run(4);

    // Randomised sequences with occasional stuck readback bits.
    for (int r = 0; r < 10; r++) begin
      for (int a = 0; a < D; a++) write_word(a, 4'($urandom_range(0, 15)), 1'b1);
      stuck = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'd0;
      run($urandom_range(1, 15));
      stuck = '0;
    end

    check("scoreboard empty", 32'(q0.size() + q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
